cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 exception/interrupt controller for the P7 pipeline; sits alongside the MEM stage.
- Consumes the MEM-stage PC, branch-delay flag and exception code, plus the six external hardware interrupt lines.
- Decides whether to take an exception or interrupt and raises req. req flushes every pipeline register and redirects fetch to 0x0000_4180.
- Holds SR, Cause, EPC and PRId; services mfc0/mtc0; clears EXL on eret.

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_exc_ctrl.sv | 80 ++++++++
 tb/tb_cp0_exc_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception codes and SR/Cause field positions.
package cp0_pkg;
    localparam logic [4:0]  CP0_SR    = 5'd12;
    localparam logic [4:0]  CP0_CAUSE = 5'd13;
    localparam logic [4:0]  CP0_EPC   = 5'd14;
    localparam logic [4:0]  CP0_PRID  = 5'd15;

    localparam logic [4:0]  EXC_INT     = 5'd0;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;
    localparam logic [4:0]  EXC_ADES    = 5'd5;
    localparam logic [4:0]  EXC_SYSCALL = 5'd8;
    localparam logic [4:0]  EXC_RI      = 5'd10;
    localparam logic [4:0]  EXC_OV      = 5'd12;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam int IM_MSB  = 15;
    localparam int IM_LSB  = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_MSB  = 15;
    localparam int IP_LSB  = 10;
    localparam int EXC_MSB = 6;
    localparam int EXC_LSB = 2;
endpackage

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 exception/interrupt controller beside the MEM stage.
// Holds SR/Cause/EPC/PRId, raises req combinationally so the flush lands on the same edge.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h5037_4350
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic        req
);
    logic [5:0]  im_q, im_d, ip_q;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d, sr_v, cause_v, epc_cand;
    logic        int_req, exc_req, sr_we, epc_we;

    assign int_req  = |(hw_int & im_q) & ie_q & ~exl_q;
    assign exc_req  = (exc_code_in != 5'd0) & ~exl_q;
    assign req      = (int_req | exc_req) & ~reset;
    // a flushed mtc0 never commits
    assign sr_we    = we & ~req & (cp0_addr == CP0_SR);
    assign epc_we   = we & ~req & (cp0_addr == CP0_EPC);
    assign epc_cand = (bd_in ? vpc - 32'd4 : vpc) & ~32'h3;
    assign epc_out  = (we && cp0_addr == CP0_EPC) ? cp0_wdata : epc_q;

    always_comb begin
        im_d  = sr_we ? cp0_wdata[IM_MSB:IM_LSB] : im_q;
        ie_d  = sr_we ? cp0_wdata[IE_BIT] : ie_q;
        exl_d = req ? 1'b1 : exl_clr ? 1'b0 : sr_we ? cp0_wdata[EXL_BIT] : exl_q;
        bd_d  = req ? bd_in : bd_q;
        exc_d = req ? (int_req ? EXC_INT : exc_code_in) : exc_q;
        epc_d = req ? epc_cand : epc_we ? cp0_wdata : epc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= hw_int;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        sr_v                    = '0;
        sr_v[IM_MSB:IM_LSB]     = im_q;
        sr_v[EXL_BIT]           = exl_q;
        sr_v[IE_BIT]            = ie_q;
        cause_v                 = '0;
        cause_v[BD_BIT]         = bd_q;
        cause_v[IP_MSB:IP_LSB]  = ip_q;
        cause_v[EXC_MSB:EXC_LSB] = exc_q;
        cp0_rdata = cp0_addr == CP0_SR    ? sr_v :
                    cp0_addr == CP0_CAUSE ? cause_v :
                    cp0_addr == CP0_EPC   ? epc_q :
                    cp0_addr == CP0_PRID  ? PRID_VAL : 32'h0;
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed scenario tasks with hand-computed expectations for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;
    localparam logic [31:0] PRID = 32'h5037_4350;

    logic        clk = 1'b0;
    logic        reset, we, bd_in, exl_clr, req;
    logic [4:0]  cp0_addr, exc_code_in;
    logic [31:0] cp0_wdata, vpc, cp0_rdata, epc_out;
    logic [5:0]  hw_int;
    int          n_cmp = 0;
    int          n_bad = 0;

    cp0_exc_ctrl #(.PRID_VAL(PRID)) dut (
        .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
        .exl_clr(exl_clr), .cp0_rdata(cp0_rdata), .epc_out(epc_out), .req(req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; cp0_addr = 5'd0; cp0_wdata = '0; bd_in = 1'b0;
        exc_code_in = 5'd0; exl_clr = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        cp0_addr = a;
        #1;
        v = cp0_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; idle(); hw_int = '0; vpc = '0;
        tick(); tick();
        reset = 1'b0;
        rd(5'd12, v); n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL reset_sr got=%h exp=%h", v, 32'h0); end
        rd(5'd13, v); n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL reset_cause got=%h exp=%h", v, 32'h0); end
        rd(5'd14, v); n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL reset_epc got=%h exp=%h", v, 32'h0); end
        rd(5'd15, v); n_cmp++;
        if (v !== PRID) begin n_bad++; $display("FAIL reset_prid got=%h exp=%h", v, PRID); end
        rd(5'd3, v); n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL other_addr got=%h exp=%h", v, 32'h0); end
        n_cmp++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", req); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
        tick(); idle();
        we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
        #1; n_cmp++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL int_idle_req got=%b exp=0", req); end
        tick(); idle();
        rd(5'd13, v); n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL cause_ro got=%h exp=%h", v, 32'h0); end
        hw_int = 6'b000001; vpc = 32'h3010;
        #1; n_cmp++;
        if (req !== 1'b1) begin n_bad++; $display("FAIL int_req got=%b exp=1", req); end
        tick();
        rd(5'd13, v); n_cmp++;
        if (v !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause got=%h exp=%h", v, 32'h0000_0400); end
        rd(5'd14, v); n_cmp++;
        if (v !== 32'h3010) begin n_bad++; $display("FAIL int_epc got=%h exp=%h", v, 32'h3010); end
        rd(5'd12, v); n_cmp++;
        if (v !== 32'h0000_FC03) begin n_bad++; $display("FAIL int_sr got=%h exp=%h", v, 32'h0000_FC03); end
        n_cmp++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL int_masked_req got=%b exp=0", req); end
        n_cmp++;
        if (epc_out !== 32'h3010) begin n_bad++; $display("FAIL epc_out_nobypass got=%h exp=%h", epc_out, 32'h3010); end
    endtask

    task automatic test_exception_bd();
        logic [31:0] v;
        hw_int = '0; exl_clr = 1'b1;
        tick(); idle();
        exc_code_in = 5'd8; bd_in = 1'b1; vpc = 32'h3024;
        #1; n_cmp++;
        if (req !== 1'b1) begin n_bad++; $display("FAIL exc_req got=%b exp=1", req); end
        tick(); idle();
        rd(5'd13, v); n_cmp++;
        if (v !== 32'h8000_0020) begin n_bad++; $display("FAIL exc_cause got=%h exp=%h", v, 32'h8000_0020); end
        rd(5'd14, v); n_cmp++;
        if (v !== 32'h3020) begin n_bad++; $display("FAIL exc_epc got=%h exp=%h", v, 32'h3020); end
    endtask

    task automatic test_nested_masked();
        logic [31:0] v;
        exc_code_in = 5'd12; hw_int = 6'h3F; vpc = 32'h3500;
        #1; n_cmp++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL nested_req got=%b exp=0", req); end
        tick(); exc_code_in = 5'd0;
        rd(5'd14, v); n_cmp++;
        if (v !== 32'h3020) begin n_bad++; $display("FAIL nested_epc got=%h exp=%h", v, 32'h3020); end
        rd(5'd13, v); n_cmp++;
        if (v !== 32'h8000_FC20) begin n_bad++; $display("FAIL nested_cause got=%h exp=%h", v, 32'h8000_FC20); end
    endtask

    task automatic test_eret_bypass();
        logic [31:0] v;
        we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h3100; exl_clr = 1'b1;
        #1; n_cmp++;
        if (epc_out !== 32'h3100) begin n_bad++; $display("FAIL epc_bypass got=%h exp=%h", epc_out, 32'h3100); end
        n_cmp++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL eret_req got=%b exp=0", req); end
        tick(); idle();
        rd(5'd12, v); n_cmp++;
        if (v !== 32'h0000_FC01) begin n_bad++; $display("FAIL eret_sr got=%h exp=%h", v, 32'h0000_FC01); end
        rd(5'd14, v); n_cmp++;
        if (v !== 32'h3100) begin n_bad++; $display("FAIL eret_epc got=%h exp=%h", v, 32'h3100); end
        exc_code_in = 5'd10; vpc = 32'h3200;
        #1; n_cmp++;
        if (req !== 1'b1) begin n_bad++; $display("FAIL pending_int_req got=%b exp=1", req); end
        tick(); idle();
        rd(5'd13, v); n_cmp++;
        if (v !== 32'h0000_FC00) begin n_bad++; $display("FAIL int_prio_cause got=%h exp=%h", v, 32'h0000_FC00); end
        rd(5'd14, v); n_cmp++;
        if (v !== 32'h3200) begin n_bad++; $display("FAIL int_prio_epc got=%h exp=%h", v, 32'h3200); end
    endtask

    task automatic test_mtc0_suppressed();
        logic [31:0] v;
        hw_int = '0; exl_clr = 1'b1;
        tick(); idle();
        we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0; exc_code_in = 5'd4; bd_in = 1'b1; vpc = 32'h0;
        #1; n_cmp++;
        if (req !== 1'b1) begin n_bad++; $display("FAIL adel_req got=%b exp=1", req); end
        tick(); idle();
        rd(5'd12, v); n_cmp++;
        if (v !== 32'h0000_FC03) begin n_bad++; $display("FAIL suppressed_sr got=%h exp=%h", v, 32'h0000_FC03); end
        rd(5'd13, v); n_cmp++;
        if (v !== 32'h8000_0010) begin n_bad++; $display("FAIL adel_cause got=%h exp=%h", v, 32'h8000_0010); end
        rd(5'd14, v); n_cmp++;
        if (v !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_epc got=%h exp=%h", v, 32'hFFFF_FFFC); end
    endtask

    task automatic test_reset_mid_handler();
        logic [31:0] v;
        hw_int = 6'h3F; exl_clr = 1'b1;
        tick(); idle();
        reset = 1'b1; exc_code_in = 5'd5;
        #1; n_cmp++;
        if (req !== 1'b0) begin n_bad++; $display("FAIL reset_forces_req got=%b exp=0", req); end
        tick(); reset = 1'b0; idle(); hw_int = '0;
        rd(5'd12, v); n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL mid_reset_sr got=%h exp=%h", v, 32'h0); end
        rd(5'd14, v); n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL mid_reset_epc got=%h exp=%h", v, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_nested_masked();
        test_eret_bypass();
        test_mtc0_suppressed();
        test_reset_mid_handler();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
